serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 84 ++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and WIDTH legality bounds for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder around one full-adder cell, with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
    logic             carry_q, cout_q, fa_sum, fa_cout;
    logic [CW-1:0]    cnt_q;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
    assign res_d = WIDTH'({fa_sum, res_q} >> 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    carry_q <= cin;
                    cnt_q   <= '0;
                    state_q <= ADD;
                end
                ADD: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
